// File: rtl/alu_mw_seq.sv
// alu_mw_seq: runs one WORDS*N-bit ALU operation as WORDS back-to-back passes
// through a shared N-bit ALU, least significant word first, chaining carry/borrow.
module alu_mw_seq #(
   parameter int N = 8,
   parameter int WORDS = 4,
   parameter int AC_N = 3,
   parameter logic [AC_N-1:0] AC_AD = AC_N'(0),
   parameter logic [AC_N-1:0] AC_SB = AC_N'(1),
   parameter logic [AC_N-1:0] AC_AN = AC_N'(2),
   parameter logic [AC_N-1:0] AC_OR = AC_N'(3),
   parameter logic [AC_N-1:0] AC_LS = AC_N'(4)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AC_N-1:0]       op,
   input  logic                  cin,
   input  logic [N*WORDS-1:0]    a_in,
   input  logic [N*WORDS-1:0]    b_in,
   output logic                  busy,
   output logic                  done,
   output logic [N*WORDS-1:0]    result,
   output logic                  carry,
   output logic                  zero,
   output logic                  err,
   output logic [N-1:0]          alu_a,
   output logic [N-1:0]          alu_b,
   output logic                  alu_cin,
   output logic [AC_N-1:0]       alu_cs,
   input  logic [N-1:0]          alu_s,
   input  logic                  alu_cout
);
   localparam int W = N*WORDS;
   localparam int IW = $clog2(WORDS);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nx;
   logic [AC_N-1:0] op_q;
   logic [W-1:0] a_q, b_q;
   logic [IW-1:0] idx;
   logic chain, run, last, accept, op_ok, is_arith, is_ls;
   assign run = state == RUN;
   assign accept = start && !run;
   assign last = idx == IW'(WORDS-1);
   assign op_ok = op inside {AC_AD, AC_SB, AC_AN, AC_OR, AC_LS};
   assign is_arith = op_q == AC_AD || op_q == AC_SB;
   assign is_ls = op_q == AC_LS;
   assign busy = run;
   assign done = state == FIN;
   assign zero = ~|result;
   // LS is a subtract whose only useful output is the final borrow
   always_comb begin
      state_nx = run ? (last ? FIN : RUN) : accept ? (op_ok ? RUN : FIN) : IDLE;
      alu_a = run ? a_q[idx*N +: N] : '0;
      alu_b = run ? b_q[idx*N +: N] : '0;
      alu_cs = !run ? AC_AD : is_ls ? AC_SB : op_q;
      alu_cin = run && chain;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         idx <= '0;
         chain <= 1'b0;
         result <= '0;
         carry <= 1'b0;
         err <= 1'b0;
      end else if (accept) begin
         op_q <= op;
         a_q <= a_in;
         b_q <= b_in;
         idx <= '0;
         chain <= cin && (op == AC_AD || op == AC_SB);
         result <= '0;
         carry <= 1'b0;
         err <= !op_ok;
      end else if (run) begin
         if (!is_ls) result[idx*N +: N] <= alu_s;
         chain <= alu_cout && (is_arith || is_ls);
         idx <= idx + 1'b1;
         if (last) carry <= is_arith && alu_cout;
         if (last && is_ls) result <= {{(W-1){1'b0}}, alu_cout};
      end
   end
endmodule

// File: tb/tb_alu_mw_seq.sv
// tb_alu_mw_seq: scoreboard bench for alu_mw_seq with an N-bit ALU model and a
// full-width arithmetic reference model.
module tb_alu_mw_seq;
   localparam int N = 8;
   localparam int WORDS = 4;
   localparam int W = N*WORDS;
   localparam logic [2:0] AD = 3'd0, SB = 3'd1, AN = 3'd2, OR = 3'd3, LS = 3'd4;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
   logic [2:0] op = '0;
   logic [W-1:0] a_in = '0, b_in = '0, result;
   logic busy, done, carry, zero, err, alu_cin, alu_cout;
   logic [N-1:0] alu_a, alu_b, alu_s;
   logic [2:0] alu_cs;
   int cyc = 0, checks = 0, passed = 0, dones = 0, d0 = 0;
   typedef struct {logic [W-1:0] r; logic c; logic e; int at;} exp_t;
   exp_t sb[$];
   exp_t m_e;
   alu_mw_seq #(.N(N), .WORDS(WORDS), .AC_N(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin),
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
      .carry(carry), .zero(zero), .err(err), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cin(alu_cin), .alu_cs(alu_cs), .alu_s(alu_s), .alu_cout(alu_cout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // the shared N-bit ALU; cout on subtract means borrow
   always_comb begin
      {alu_cout, alu_s} = '0;
      if (alu_cs == AD) {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      else if (alu_cs == SB) {alu_cout, alu_s} = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
      else if (alu_cs == AN) alu_s = alu_a & alu_b;
      else if (alu_cs == OR) alu_s = alu_a | alu_b;
   end
   task automatic chk(string name, longint unsigned act, longint unsigned exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   function automatic exp_t model(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b, logic c);
      longint unsigned la = a, lb = b, lc = c;
      exp_t e;
      e.r = '0; e.c = 1'b0; e.e = 1'b0; e.at = 0;
      case (o)
         AD: begin e.r = W'(la + lb + lc); e.c = (la + lb + lc) >= 64'h1_0000_0000; end
         SB: begin e.r = W'(la - lb - lc); e.c = la < lb + lc; end
         AN: e.r = a & b;
         OR: e.r = a | b;
         LS: e.r = (a < b) ? 1 : 0;
         default: e.e = 1'b1;
      endcase
      return e;
   endfunction
   task automatic issue(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b, logic c);
      exp_t e;
      int n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      if (busy) begin checks++; $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n); end
      e = model(o, a, b, c);
      e.at = cyc + 1 + (e.e ? 0 : WORDS);
      sb.push_back(e);
      start = 1'b1; op = o; a_in = a; b_in = b; cin = c;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a_in = $urandom; b_in = $urandom; cin = 1'($urandom);
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: pending %0d, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask
   task automatic chk_reset_state();
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
      chk("rst_carry", carry, 0); chk("rst_zero", zero, 1); chk("rst_err", err, 0);
      chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_cin", alu_cin, 0); chk("rst_alu_cs", alu_cs, AD);
   endtask
   initial forever begin
      @(posedge clk); #1;
      if (done) begin
         dones++;
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL stray_done: done=1 with no operation pending, required done=0");
         end else begin
            m_e = sb.pop_front();
            chk("result", result, m_e.r);
            chk("carry", carry, m_e.c);
            chk("zero", zero, m_e.r == 0);
            chk("err", err, m_e.e);
            chk("done_cycle", cyc, m_e.at);
            chk("busy_at_done", busy, 0);
         end
      end
   end
   initial begin
      logic [W-1:0] ra, rb;
      repeat (3) @(negedge clk);
      chk_reset_state();
      rst_n = 1'b1;
      @(negedge clk);
      issue(AD, 32'h00FFFFFF, 32'h00000001, 1'b0);
      issue(AD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      issue(SB, 32'h00000000, 32'h00000001, 1'b0);
      issue(SB, 32'h00000005, 32'h00000003, 1'b1);
      issue(LS, 32'h12345678, 32'h12345679, 1'b0);
      issue(LS, 32'h12345678, 32'h12345678, 1'b1);
      issue(AN, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
      issue(3'd5, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      issue(OR, 32'hF0F0F0F0, 32'h0F0F0F00, 1'b0);
      issue(3'd7, 32'h1, 32'h2, 1'b1);
      drain();
      chk("idle_alu_cs", alu_cs, AD);
      chk("idle_alu_a", alu_a, 0);
      d0 = dones;
      issue(AD, 32'h89ABCDEF, 32'h76543211, 1'b0);
      while (busy) begin
         start = 1'b1; op = 3'($urandom_range(0, 7)); a_in = $urandom; b_in = $urandom;
         @(negedge clk);
      end
      start = 1'b0;
      drain();
      chk("dones_ignored_start", dones - d0, 1);
      issue(AD, 32'h11111111, 32'h22222222, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      sb.delete();
      d0 = dones;
      repeat (4) @(negedge clk);
      chk("dones_during_reset", dones - d0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(SB, 32'h10000000, 32'h00000001, 1'b0);
      drain();
      repeat (150) begin
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         issue(3'($urandom_range(0, 7)), ra, rb, 1'($urandom));
      end
      drain();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
